// File: rtl/passcode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : passcode_pkg
// Purpose  : Shared encodings for the manual-override passcode arbiter:
//            FSM state codes, keypad key codes and a digit classifier.
// Revision : 1.0 - initial release
// ============================================================================
package passcode_pkg;

    // FSM state encoding (3 bits, five states)
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_AUTO    = 3'd0;
    localparam logic [2:0] ST_MANUAL  = 3'd1;
    localparam logic [2:0] ST_ENTRY   = 3'd2;
    localparam logic [2:0] ST_FULL    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    // Keypad codes; 0-9 are digits, D/E carry no meaning
    localparam logic [3:0] KEY_START = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_OK    = 4'hC;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/passcode_ctrl_arbiter_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Free-running prescaler producing a one-clk tick every
//            2^TICK_DIV clocks, plus tick-rate keypad sampling with a
//            two-sample agreement filter and a press-edge event.
// Ports    : clk, reset (async, active-low)
//            key_code [3:0]  raw keypad code (F = no key)
//            tick            one-clk pulse when the prescaler is all-ones
//            key_evt         one-clk pulse (coincident with tick) when the
//                            debounced key goes from F to a pressed code
//            key_val [3:0]   code carried by key_evt
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import passcode_pkg::*;
#(
    parameter int TICK_DIV = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic       tick,
    output logic       key_evt,
    output logic [3:0] key_val
);

    logic [TICK_DIV-1:0] r_presc;
    logic [3:0]          r_samp;
    logic [3:0]          r_stable;
    logic                w_tick;
    logic                w_agree;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TICK_DIV'(1);
        end
    end

    assign w_tick  = &r_presc;
    // The stable register only follows the input when two consecutive
    // tick samples agree.
    assign w_agree = (key_code == r_samp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp   <= KEY_NONE;
            r_stable <= KEY_NONE;
        end else if (w_tick) begin
            r_samp <= key_code;
            if (w_agree) begin
                r_stable <= key_code;
            end
        end
    end

    // Fires in the same tick cycle in which r_stable is about to take a
    // pressed code while currently idle; holding a key cannot re-fire
    // because r_stable is no longer KEY_NONE.
    assign key_evt = w_tick && w_agree && (r_stable == KEY_NONE) &&
                     (key_code != KEY_NONE);
    assign key_val = key_code;
    assign tick    = w_tick;

endmodule
`default_nettype wire

// File: rtl/passcode_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : passcode_ctrl_arbiter
// Purpose  : Arbitrates between the autonomous and the human-sensor command
//            source and runs the keypad passcode entry that hands control
//            back to the autonomous source. Includes a failed-attempt counter
//            with timed lockout and a wrong-code beep pulse.
// Ports    : clk, reset (async, active-low)
//            cmd_auto   [CMD_W]     autonomous command
//            cmd_manual [CMD_W]     human command, nonzero requests override
//            key_code   [4]         keypad code
//            cmd_out    [CMD_W]     registered arbitrated command
//            disp       [4*DIGITS]  BCD digits entered, right-aligned
//            beep                   wrong-code pulse
//            manual_mode            high in every state except AUTO
//            lockout                high while locked out
//            pwd_we, pwd_din        passcode load (PWD_LOAD_EN only)
// Config   : `define PWD_LOAD_EN to make the passcode loadable in AUTO.
// Revision : 1.0 - initial release
// ============================================================================
module passcode_ctrl_arbiter
    import passcode_pkg::*;
#(
    parameter int                  CMD_W      = 3,
    parameter int                  DIGITS     = 4,
    parameter logic [4*DIGITS-1:0] PASSCODE   = 16'h2018,
    parameter int                  TICK_DIV   = 20,
    parameter int                  MAX_TRIES  = 3,
    parameter int                  LOCK_TICKS = 256,
    parameter int                  BEEP_TICKS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CMD_W-1:0]      cmd_auto,
    input  logic [CMD_W-1:0]      cmd_manual,
    input  logic [3:0]            key_code,
    output logic [CMD_W-1:0]      cmd_out,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  beep,
    output logic                  manual_mode,
    output logic                  lockout
`ifdef PWD_LOAD_EN
    ,
    input  logic                  pwd_we,
    input  logic [4*DIGITS-1:0]   pwd_din
`endif
);

    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int LCNT_W = $clog2(LOCK_TICKS + 1);
    localparam int BCNT_W = $clog2(BEEP_TICKS + 1);

    localparam logic [CNT_W-1:0]  c_last_digit = CNT_W'(DIGITS - 1);
    localparam logic [TRY_W-1:0]  c_max_tries  = TRY_W'(MAX_TRIES);
    localparam logic [LCNT_W-1:0] c_lock_last  = LCNT_W'(LOCK_TICKS - 1);
    localparam logic [BCNT_W-1:0] c_beep_last  = BCNT_W'(BEEP_TICKS - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [TRY_W-1:0]     r_tries;
    logic [LCNT_W-1:0]    r_lock_cnt;
    logic [BCNT_W-1:0]    r_beep_cnt;
    logic                 r_beep;
    logic [4*DIGITS-1:0]  r_buf;
    logic [4*DIGITS-1:0]  r_disp;
    logic [CMD_W-1:0]     r_cmd_out;

    logic                 w_tick;
    logic                 w_key_evt;
    logic [3:0]           w_key_val;
    logic [4*DIGITS-1:0]  w_buf_shift;
    logic [4*DIGITS-1:0]  w_passcode;
    logic [TRY_W-1:0]     w_tries_inc;

    key_debounce #(
        .TICK_DIV (TICK_DIV)
    ) u_key_debounce (
        .clk      (clk),
        .reset    (reset),
        .key_code (key_code),
        .tick     (w_tick),
        .key_evt  (w_key_evt),
        .key_val  (w_key_val)
    );

    // New digit enters at the LS nibble; a single-digit buffer is simply
    // replaced.
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign w_buf_shift = w_key_val;
        end else begin : g_shift_multi
            assign w_buf_shift = {r_buf[4*DIGITS-5:0], w_key_val};
        end
    endgenerate

`ifdef PWD_LOAD_EN
    logic [4*DIGITS-1:0] r_passcode;

    // Loads are honoured on any clk, but only while control is autonomous.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_passcode <= PASSCODE;
        end else if (pwd_we && (r_state == ST_AUTO)) begin
            r_passcode <= pwd_din;
        end
    end

    assign w_passcode = r_passcode;
`else
    assign w_passcode = PASSCODE;
`endif

    assign w_tries_inc = r_tries + TRY_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_AUTO;
            r_count    <= '0;
            r_tries    <= '0;
            r_lock_cnt <= '0;
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
            r_buf      <= '0;
            r_disp     <= '0;
        end else if (w_tick) begin
            // Beep timer runs independently of the FSM; a new mismatch
            // below overrides this and restarts the pulse.
            if (r_beep) begin
                if (r_beep_cnt == '0) begin
                    r_beep <= 1'b0;
                end else begin
                    r_beep_cnt <= r_beep_cnt - BCNT_W'(1);
                end
            end

            case (r_state)
                ST_AUTO: begin
                    if (cmd_manual != '0) begin
                        r_state <= ST_MANUAL;
                    end
                end

                ST_MANUAL: begin
                    if (w_key_evt && (w_key_val == KEY_START)) begin
                        r_state <= ST_ENTRY;
                        r_buf   <= '0;
                        r_disp  <= '0;
                        r_count <= '0;
                    end
                end

                ST_ENTRY: begin
                    if (w_key_evt) begin
                        if (is_digit(w_key_val)) begin
                            // Buffer and display hold the same digits
                            // throughout entry.
                            r_buf   <= w_buf_shift;
                            r_disp  <= w_buf_shift;
                            r_count <= r_count + CNT_W'(1);
                            if (r_count == c_last_digit) begin
                                r_state <= ST_FULL;
                            end
                        end else if (w_key_val == KEY_CLR) begin
                            r_buf   <= '0;
                            r_disp  <= '0;
                            r_count <= '0;
                        end
                    end
                end

                ST_FULL: begin
                    if (w_key_evt) begin
                        if (w_key_val == KEY_OK) begin
                            r_disp <= '0;
                            if (r_buf == w_passcode) begin
                                r_state <= ST_AUTO;
                                r_tries <= '0;
                            end else begin
                                r_tries    <= w_tries_inc;
                                r_beep     <= 1'b1;
                                r_beep_cnt <= c_beep_last;
                                if (w_tries_inc == c_max_tries) begin
                                    r_state    <= ST_LOCKOUT;
                                    r_lock_cnt <= '0;
                                end else begin
                                    r_state <= ST_MANUAL;
                                end
                            end
                        end else if (w_key_val == KEY_CLR) begin
                            r_state <= ST_ENTRY;
                            r_buf   <= '0;
                            r_disp  <= '0;
                            r_count <= '0;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    // Exit on the LOCK_TICKS-th tick after entry.
                    if (r_lock_cnt == c_lock_last) begin
                        r_state <= ST_MANUAL;
                        r_tries <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + LCNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_AUTO;
                end
            endcase
        end
    end

    // Arbitration is evaluated every clk from the registered state, so a
    // state change on a tick reaches cmd_out one clk later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_out <= '0;
        end else begin
            r_cmd_out <= (r_state == ST_AUTO) ? cmd_auto : cmd_manual;
        end
    end

    assign cmd_out     = r_cmd_out;
    assign disp        = r_disp;
    assign beep        = r_beep;
    assign manual_mode = (r_state != ST_AUTO);
    assign lockout     = (r_state == ST_LOCKOUT);

endmodule
`default_nettype wire

// File: tb/tb_passcode_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_passcode_ctrl_arbiter
// Purpose  : Directed self-checking bench for passcode_ctrl_arbiter with
//            TICK_DIV=2 (one tick every 4 clk), DIGITS=4, MAX_TRIES=3,
//            LOCK_TICKS=8, BEEP_TICKS=4. Expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_passcode_ctrl_arbiter;

    localparam int TPT = 4; // clk per tick

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cmd_auto;
    logic [2:0]  cmd_manual;
    logic [3:0]  key_code;
    logic [2:0]  cmd_out;
    logic [15:0] disp;
    logic        beep;
    logic        manual_mode;
    logic        lockout;
`ifdef PWD_LOAD_EN
    logic        pwd_we;
    logic [15:0] pwd_din;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int beep_clks = 0;
    int lock_clks = 0;

    always #5 clk = ~clk;

    passcode_ctrl_arbiter #(
        .CMD_W      (3),
        .DIGITS     (4),
        .PASSCODE   (16'h2018),
        .TICK_DIV   (2),
        .MAX_TRIES  (3),
        .LOCK_TICKS (8),
        .BEEP_TICKS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_auto    (cmd_auto),
        .cmd_manual  (cmd_manual),
        .key_code    (key_code),
        .cmd_out     (cmd_out),
        .disp        (disp),
        .beep        (beep),
        .manual_mode (manual_mode),
        .lockout     (lockout)
`ifdef PWD_LOAD_EN
        ,
        .pwd_we      (pwd_we),
        .pwd_din     (pwd_din)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n falling edges, accumulating beep/lockout high time.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (beep)    beep_clks++;
            if (lockout) lock_clks++;
        end
    endtask

    // Hold a key for 'hold' ticks, then release for 3 ticks.
    task automatic press(input logic [3:0] k, input int hold);
        key_code = k;
        step(hold * TPT);
        key_code = 4'hF;
        step(3 * TPT);
    endtask

    task automatic enter_code(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        press(4'hA, 3);
        for (int i = 3; i >= 0; i--) press(c[4*i +: 4], 3);
    endtask

    task automatic wait_manual();
        int n;
        n = 0;
        while (!manual_mode && n < 40) begin
            step(1);
            n++;
        end
        chk("manual_entry", manual_mode, 1);
    endtask

    task automatic wait_unlock();
        int n;
        n = 0;
        while (lockout && n < 200) begin
            step(1);
            n++;
        end
        chk("lockout_release", lockout, 0);
    endtask

    initial begin
        reset      = 1'b0;
        cmd_auto   = 3'd0;
        cmd_manual = 3'd0;
        key_code   = 4'hF;
`ifdef PWD_LOAD_EN
        pwd_we     = 1'b0;
        pwd_din    = 16'h0;
`endif
        step(3);
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_disp", disp, 0);
        chk("rst_beep", beep, 0);
        chk("rst_manual", manual_mode, 0);
        chk("rst_lockout", lockout, 0);
        reset = 1'b1;

        // 1. Arbitration and AUTO -> MANUAL latency
        cmd_auto = 3'b101;
        step(3);
        chk("auto_cmd", cmd_out, 5);
        chk("auto_mode", manual_mode, 0);
        cmd_manual = 3'b010;
        wait_manual();
        chk("cmd_hold_on_tick", cmd_out, 5);
        step(1);
        chk("cmd_manual_after", cmd_out, 2);

        // 2. Correct code unlocks
        press(4'hA, 3); chk("t2_A", disp, 16'h0000);
        press(4'h2, 3); chk("t2_d1", disp, 16'h0002);
        press(4'h0, 3); chk("t2_d2", disp, 16'h0020);
        press(4'h1, 3); chk("t2_d3", disp, 16'h0201);
        press(4'h8, 3); chk("t2_d4", disp, 16'h2018);
        cmd_manual = 3'd0;
        press(4'hC, 3);
        chk("t2_mode", manual_mode, 0);
        chk("t2_cmd", cmd_out, 5);
        chk("t2_disp", disp, 0);
        chk("t2_beep", beep, 0);

        // 3. Repeated digits, mismatch, beep length
        cmd_manual = 3'b010;
        wait_manual();
        press(4'hA, 3);
        press(4'h1, 3); chk("t3_d1", disp, 16'h0001);
        press(4'h1, 3); chk("t3_d2", disp, 16'h0011);
        press(4'h2, 3); chk("t3_d3", disp, 16'h0112);
        press(4'h2, 3); chk("t3_d4", disp, 16'h1122);
        beep_clks = 0;
        press(4'hC, 3);
        step(8);
        chk("t3_beep_len", beep_clks, 16);
        chk("t3_mode", manual_mode, 1);
        chk("t3_disp", disp, 0);
        chk("t3_lockout", lockout, 0);

        // 4. Third wrong code locks out; lockout ignores keys; tries reset
        enter_code(16'h9999);
        press(4'hC, 3);
        chk("t4_no_lock_2", lockout, 0);
        enter_code(16'h1234);
        lock_clks = 0;
        press(4'hC, 3);
        chk("t4_lock", lockout, 1);
        press(4'hA, 3);
        wait_unlock();
        chk("t4_lock_len", lock_clks, 32);
        chk("t4_mode", manual_mode, 1);
        press(4'h5, 3);
        chk("t4_keys_ignored", disp, 0);
        enter_code(16'h1111);
        press(4'hC, 3);
        enter_code(16'h2222);
        press(4'hC, 3);
        chk("t4_tries_reset", lockout, 0);
        enter_code(16'h3333);
        press(4'hC, 3);
        chk("t4_relock", lockout, 1);
        wait_unlock();
        cmd_manual = 3'd0;
        enter_code(16'h2018);
        press(4'hC, 3);
        chk("t4_unlock", manual_mode, 0);
        chk("t4_cmd", cmd_out, 5);

        // 5. Clear mid-entry and long hold
        cmd_manual = 3'b010;
        wait_manual();
        press(4'hA, 3);
        press(4'h2, 3);
        press(4'h0, 3); chk("t5_pre_clr", disp, 16'h0020);
        press(4'hB, 3); chk("t5_clr", disp, 16'h0000);
        press(4'h2, 10); chk("t5_long_hold", disp, 16'h0002);
        press(4'h0, 3);
        press(4'h1, 3);
        press(4'h8, 3); chk("t5_full", disp, 16'h2018);
        cmd_manual = 3'd0;
        press(4'hC, 3);
        chk("t5_unlock", manual_mode, 0);

        // 6. Asynchronous reset mid-entry
        cmd_manual = 3'b010;
        wait_manual();
        press(4'hA, 3);
        press(4'h2, 3);
        press(4'h0, 3); chk("t6_pre_rst", disp, 16'h0020);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_disp", disp, 0);
        chk("t6_rst_cmd", cmd_out, 0);
        chk("t6_rst_mode", manual_mode, 0);
        chk("t6_rst_beep", beep, 0);
        chk("t6_rst_lock", lockout, 0);
        step(2);
        cmd_manual = 3'd0;
        reset = 1'b1;
        step(3);
        chk("t6_auto_cmd", cmd_out, 5);
        chk("t6_auto_mode", manual_mode, 0);

`ifdef PWD_LOAD_EN
        pwd_we  = 1'b1;
        pwd_din = 16'h4321;
        step(1);
        pwd_we  = 1'b0;
        cmd_manual = 3'b010;
        wait_manual();
        cmd_manual = 3'd0;
        enter_code(16'h4321);
        press(4'hC, 3);
        chk("ld_unlock", manual_mode, 0);
        cmd_manual = 3'b010;
        wait_manual();
        // Load outside AUTO must be ignored.
        pwd_we  = 1'b1;
        pwd_din = 16'h2018;
        step(1);
        pwd_we  = 1'b0;
        cmd_manual = 3'd0;
        enter_code(16'h2018);
        beep_clks = 0;
        press(4'hC, 3);
        step(8);
        chk("ld_old_fails", manual_mode, 1);
        chk("ld_old_beep", beep_clks, 16);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
